// File: rtl/bcd_event_counter.sv
// Multi-digit BCD event counter with wrap/saturate overflow handling and an
// active-low 7-segment decode per digit, with optional leading-zero blanking.
module bcd_event_counter #(
  parameter int NDIG  = 3,
  parameter int SAT   = 0,
  parameter int BLANK = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic                Hold,
  input  logic                Clear,
  output logic [4*NDIG-1:0]   BCD,
  output logic [7*NDIG-1:0]   HEX,
  output logic                Carry,
  output logic                Ovf
);

  logic [4*NDIG-1:0] bcd_q;
  logic [4*NDIG-1:0] bcd_inc;
  logic [NDIG:0]     ripple;   // ripple[i]: digit i increments this event
  logic              accept;
  logic              ovf_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign accept = Reset_n && !Clear && !Hold && Enable;

  // Ripple the increment upward; ripple[NDIG] means the count was all-9s.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    ripple    = '0;
    bcd_inc   = bcd_q;
    ripple[0] = accept;
    for (int i = 0; i < NDIG; i++) begin
      if (ripple[i])
        bcd_inc[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
      ripple[i+1] = ripple[i] && (bcd_q[4*i +: 4] == 4'd9);
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!Reset_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (Clear) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (ripple[NDIG])
        ovf_q <= 1'b1;
      if (!(ripple[NDIG] && SAT != 0))
        bcd_q <= bcd_inc;
    end
  end

  // Walk from the top digit down; a digit is blanked while it and all higher
  // digits are zero. Digit 0 always shows.
  always_comb begin
    logic zero_above;
    HEX        = '1;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      if (BLANK != 0 && i > 0 && zero_above)
        HEX[7*i +: 7] = 7'b1111111;
      else
        HEX[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
  end

  assign BCD   = bcd_q;
  assign Ovf   = ovf_q;
  assign Carry = ripple[NDIG] && (SAT == 0);

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: two 3-digit counters (wrap+blank, saturate+no-blank)
// driven in lockstep and compared against an integer reference model.
module tb_bcd_event_counter;

  logic        clock = 1'b0;
  logic        reset_n, enable, hold, clear;
  logic [11:0] bcd0, bcd1;
  logic [20:0] hex0, hex1;
  logic        carry0, carry1, ovf0, ovf1;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt   [2];
  bit ovf_m [2];

  always #5 clock = ~clock;

  bcd_event_counter #(.NDIG(3), .SAT(0), .BLANK(1)) dut_wrap (
    .Clock(clock), .Reset_n(reset_n), .Enable(enable), .Hold(hold), .Clear(clear),
    .BCD(bcd0), .HEX(hex0), .Carry(carry0), .Ovf(ovf0));

  bcd_event_counter #(.NDIG(3), .SAT(1), .BLANK(0)) dut_sat (
    .Clock(clock), .Reset_n(reset_n), .Enable(enable), .Hold(hold), .Clear(clear),
    .BCD(bcd1), .HEX(hex1), .Carry(carry1), .Ovf(ovf1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [11:0] bcd_ref(input int c);
    return {4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  function automatic logic [20:0] hex_ref(input int c, input bit blank);
    int pw [3] = '{1, 10, 100};
    logic [20:0] h;
    for (int i = 0; i < 3; i++) begin
      if (blank && i > 0 && c < pw[i]) h[7*i +: 7] = 7'b1111111;
      else                             h[7*i +: 7] = seg_ref(c / pw[i] % 10);
    end
    return h;
  endfunction

  task automatic compare_all();
    bit acc;
    acc = reset_n && enable && !hold && !clear;
    check("w_bcd",   32'(bcd0),   32'(bcd_ref(cnt[0])));
    check("w_hex",   32'(hex0),   32'(hex_ref(cnt[0], 1'b1)));
    check("w_carry", 32'(carry0), 32'(acc && cnt[0] == 999));
    check("w_ovf",   32'(ovf0),   32'(ovf_m[0]));
    check("s_bcd",   32'(bcd1),   32'(bcd_ref(cnt[1])));
    check("s_hex",   32'(hex1),   32'(hex_ref(cnt[1], 1'b0)));
    check("s_carry", 32'(carry1), 32'(0));
    check("s_ovf",   32'(ovf1),   32'(ovf_m[1]));
  endtask

  task automatic apply(input bit r, input bit e, input bit h, input bit c);
    @(negedge clock);
    reset_n = r; enable = e; hold = h; clear = c;
    #1 compare_all();
  endtask

  // Advance one edge and update the model from the sampled inputs.
  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n || clear) begin
        cnt[k] = 0; ovf_m[k] = 0;
      end else if (enable && !hold) begin
        if (cnt[k] == 999) begin
          ovf_m[k] = 1;
          if (k == 0) cnt[k] = 0;
        end else cnt[k]++;
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit e, input bit h, input bit c);
    apply(r, e, h, c);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; hold = 1'b0; clear = 1'b0;
    cnt = '{0, 0}; ovf_m = '{0, 0};

    // Reset two cycles, then 12 single-cycle pulses.
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    apply(1, 0, 0, 0);
    check("rst_bcd", 32'(bcd0), 32'h000);
    check("rst_hex", 32'(hex0), 32'h1fffc0);
    check("rst_hex_noblank", 32'(hex1), {11'd0, 7'b1000000, 7'b1000000, 7'b1000000});
    tick();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
    end
    check("p12_bcd", 32'(bcd0), 32'h012);
    check("p12_hex", 32'(hex0), {11'd0, 7'b1111111, 7'b1111001, 7'b0100100});

    // 099 -> 100 with no carry.
    step(1, 0, 0, 1);
    for (int i = 0; i < 99; i++) step(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    check("c099_carry", 32'(carry0), 32'd0);
    tick();
    check("c100_bcd", 32'(bcd0), 32'h100);

    // Load 999, then wrap vs saturate.
    step(1, 0, 0, 1);
    for (int i = 0; i < 999; i++) step(1, 1, 0, 0);
    check("c999_bcd", 32'(bcd0), 32'h999);
    apply(1, 1, 0, 0);
    check("wrap_carry", 32'(carry0), 32'd1);
    tick();
    check("wrap_bcd", 32'(bcd0), 32'h000);
    check("wrap_ovf", 32'(ovf0), 32'd1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("sat_bcd", 32'(bcd1), 32'h999);
    check("sat_ovf", 32'(ovf1), 32'd1);
    step(1, 0, 0, 1);
    check("clr_ovf", 32'(ovf0), 32'd0);

    // Clear beats Enable; Hold loses events.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    check("c005_bcd", 32'(bcd0), 32'h005);
    step(1, 1, 0, 1);
    check("clr_en_bcd", 32'(bcd0), 32'h000);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    check("hold_bcd", 32'(bcd0), 32'h000);

    // Reset glitch between edges has no effect; reset across an edge does.
    for (int i = 0; i < 47; i++) step(1, 1, 0, 0);
    @(negedge clock);
    enable = 1'b0;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    #1 compare_all();
    tick();
    check("glitch_bcd", 32'(bcd0), 32'h047);
    step(0, 1, 0, 0);
    check("rst_mid_bcd", 32'(bcd0), 32'h000);
    check("rst_mid_ovf", 32'(ovf1), 32'd0);
    step(1, 1, 0, 0);
    check("post_rst_bcd", 32'(bcd0), 32'h001);

    // Randomized traffic, long enough to wrap.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      step(!(r < 2), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, (r >= 2 && r < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
